// File: rtl/rx_frame_checker.sv
// rx_frame_checker: pulls framed words from an FWFT FIFO, locks onto the
// 0xCAFE header, forwards the payload over a valid/ready stream, recomputes
// the CRC-16 and checks the 0xC0DE trailer. Exposes per-frame status pulses
// and saturating good/bad frame counters.
module rx_frame_checker #(
    parameter int NB_SAMPLES = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_fifo_empty,
    input  logic [31:0] i_fifo_data,
    output logic        o_fifo_pull,
    output logic        o_valid,
    output logic [31:0] o_data,
    output logic        o_first,
    output logic        o_last,
    input  logic        i_ready,
    output logic [63:0] o_timestamp,
    output logic [14:0] o_seqnum,
    output logic        o_frame_ok,
    output logic        o_crc_err,
    output logic        o_sync_err,
    output logic        o_seq_err,
    output logic [15:0] o_cnt_ok,
    output logic [15:0] o_cnt_bad
);

    localparam logic [15:0] HDR_TAG  = 16'hCAFE;
    localparam logic [15:0] FCS_TAG  = 16'hC0DE;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [9:0]  CNT_LAST = 10'(NB_SAMPLES - 1);

    typedef enum logic [2:0] {
        HUNT,
        TS_MSB,
        TS_LSB,
        PAYLOAD,
        FCS
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [9:0]  count;          // payload words still to take after the current one
    logic [15:0] crc;
    logic        baseline;       // a header has been seen since reset
    logic        hdr_match;
    logic        tag_ok;
    logic        crc_ok;
    logic [14:0] seq_expected;

    // Runs one 32-bit word through the CRC-16 shift register, MSB first.
    function automatic logic [15:0] crc_word(input logic [15:0] c_in, input logic [31:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 31; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

    assign hdr_match    = (i_fifo_data[31:15] == {HDR_TAG, 1'b0});
    assign tag_ok       = (i_fifo_data[31:16] == FCS_TAG);
    assign crc_ok       = (i_fifo_data[15:0] == crc);
    assign seq_expected = o_seqnum + 15'd1;

    // Only payload words can be held back: they wait for the downstream slot.
    assign o_fifo_pull = !i_fifo_empty && !i_reset
                         && (state != PAYLOAD || !o_valid || i_ready);

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: registered state is always written with <= so every flop
        // samples the pre-edge values of the others.
        if (i_reset) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; the FSM only advances on a pulled word.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        if (o_fifo_pull) begin
            case (state)
                HUNT:    if (hdr_match) state_next = TS_MSB;
                TS_MSB:  state_next = TS_LSB;
                TS_LSB:  state_next = PAYLOAD;
                PAYLOAD: if (count == 10'd0) state_next = FCS;
                FCS:     state_next = HUNT;
                default: state_next = HUNT;
            endcase
        end
    end

    // Datapath: header/timestamp capture, payload stream, CRC, status and counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_first     <= 1'b0;
            o_last      <= 1'b0;
            o_timestamp <= '0;
            o_seqnum    <= '0;
            o_frame_ok  <= 1'b0;
            o_crc_err   <= 1'b0;
            o_sync_err  <= 1'b0;
            o_seq_err   <= 1'b0;
            o_cnt_ok    <= '0;
            o_cnt_bad   <= '0;
            count       <= '0;
            crc         <= CRC_INIT;
            baseline    <= 1'b0;
        end else begin
            o_frame_ok <= 1'b0;
            o_crc_err  <= 1'b0;
            o_sync_err <= 1'b0;
            o_seq_err  <= 1'b0;

            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            if (o_fifo_pull) begin
                case (state)
                    HUNT: begin
                        if (hdr_match) begin
                            o_seqnum  <= i_fifo_data[14:0];
                            crc       <= CRC_INIT;
                            baseline  <= 1'b1;
                            o_seq_err <= baseline && (i_fifo_data[14:0] != seq_expected);
                        end
                    end
                    TS_MSB: begin
                        o_timestamp[63:32] <= i_fifo_data;
                    end
                    TS_LSB: begin
                        o_timestamp[31:0] <= i_fifo_data;
                        count             <= CNT_LAST;
                    end
                    PAYLOAD: begin
                        o_valid <= 1'b1;
                        o_data  <= i_fifo_data;
                        o_first <= (count == CNT_LAST);
                        o_last  <= (count == 10'd0);
                        crc     <= crc_word(crc, i_fifo_data);
                        count   <= count - 10'd1;
                    end
                    FCS: begin
                        if (!tag_ok) begin
                            o_sync_err <= 1'b1;
                            if (o_cnt_bad != 16'hFFFF) o_cnt_bad <= o_cnt_bad + 16'd1;
                        end else if (crc_ok) begin
                            o_frame_ok <= 1'b1;
                            if (o_cnt_ok != 16'hFFFF) o_cnt_ok <= o_cnt_ok + 16'd1;
                        end else begin
                            o_crc_err <= 1'b1;
                            if (o_cnt_bad != 16'hFFFF) o_cnt_bad <= o_cnt_bad + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_checker.sv
// Scoreboard bench for rx_frame_checker: frames are built from a payload
// table, expectations are queued at build time, and a monitor pops and
// compares whenever the DUT shows a payload beat or a status pulse.
module tb_rx_frame_checker;

    localparam int NB = 256;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_fifo_empty;
    logic [31:0] i_fifo_data;
    logic        o_fifo_pull;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_first;
    logic        o_last;
    logic        i_ready;
    logic [63:0] o_timestamp;
    logic [14:0] o_seqnum;
    logic        o_frame_ok;
    logic        o_crc_err;
    logic        o_sync_err;
    logic        o_seq_err;
    logic [15:0] o_cnt_ok;
    logic [15:0] o_cnt_bad;

    rx_frame_checker #(.NB_SAMPLES(NB)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_data  (i_fifo_data),
        .o_fifo_pull  (o_fifo_pull),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_first      (o_first),
        .o_last       (o_last),
        .i_ready      (i_ready),
        .o_timestamp  (o_timestamp),
        .o_seqnum     (o_seqnum),
        .o_frame_ok   (o_frame_ok),
        .o_crc_err    (o_crc_err),
        .o_sync_err   (o_sync_err),
        .o_seq_err    (o_seq_err),
        .o_cnt_ok     (o_cnt_ok),
        .o_cnt_bad    (o_cnt_bad)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        first;
        logic        last;
        logic [31:0] data;
    } beat_t;

    typedef enum logic [1:0] {ST_OK, ST_CRC, ST_SYNC} st_kind_t;

    typedef struct packed {
        st_kind_t    kind;
        logic        seq_err;
        logic [14:0] seq;
        logic [63:0] ts;
        logic [15:0] cnt_ok;
        logic [15:0] cnt_bad;
    } stat_t;

    logic [31:0] fifo[$];
    beat_t       exp_beats[$];
    stat_t       exp_stat[$];
    bit          rdy_pat[$];

    int n_cmp = 0;
    int n_bad = 0;
    int total_beats = 0;
    int seen_seqerr = 0;
    int rdy_mode = 0;      // 0: always ready, 1: random, 2: pattern queue
    bit gap_en = 0;        // random FIFO-empty bubbles
    bit pull_s = 0;
    bit have_prev = 0;
    logic  prev_valid, prev_ready;
    beat_t prev_beat;

    // Reference model state
    bit          m_base;
    logic [14:0] m_prev;
    logic [15:0] m_ok, m_bad;
    logic [31:0] pl [NB];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC-16/0x1021 over the payload table as one MSB-first bit stream.
    function automatic logic [15:0] model_crc();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int w = 0; w < NB; w++) begin
            for (int b = 31; b >= 0; b--) begin
                fb = c[15] ^ pl[w][b];
                c  = (c << 1) ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    // Serialise one frame from pl[] into the FIFO and queue its expectations.
    task automatic push_frame(input logic [14:0] seq, input logic [63:0] ts,
                              input int flip_idx, input bit bad_tag);
        logic [15:0] crc;
        logic [31:0] w;
        beat_t       b;
        stat_t       s;
        crc = model_crc();
        fifo.push_back({16'hCAFE, 1'b0, seq});
        fifo.push_back(ts[63:32]);
        fifo.push_back(ts[31:0]);
        for (int i = 0; i < NB; i++) begin
            w = pl[i];
            if (i == flip_idx) w[5] = ~w[5];
            fifo.push_back(w);
            b.first = (i == 0);
            b.last  = (i == NB - 1);
            b.data  = w;
            exp_beats.push_back(b);
        end
        fifo.push_back({bad_tag ? 16'hBEEF : 16'hC0DE, crc});
        s.kind    = bad_tag ? ST_SYNC : ((flip_idx >= 0) ? ST_CRC : ST_OK);
        s.seq_err = m_base && (seq != 15'(m_prev + 15'd1));
        m_base    = 1'b1;
        m_prev    = seq;
        if (s.kind == ST_OK) begin
            if (m_ok != 16'hFFFF) m_ok = m_ok + 16'd1;
        end else begin
            if (m_bad != 16'hFFFF) m_bad = m_bad + 16'd1;
        end
        s.seq     = seq;
        s.ts      = ts;
        s.cnt_ok  = m_ok;
        s.cnt_bad = m_bad;
        exp_stat.push_back(s);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((fifo.size() != 0 || exp_beats.size() != 0 || exp_stat.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 128'(fifo.size() + exp_beats.size() + exp_stat.size()), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        i_reset = 1'b1;
        repeat (cycles) @(negedge clk);
        i_reset = 1'b0;
        m_base  = 1'b0;
        m_prev  = '0;
        m_ok    = '0;
        m_bad   = '0;
    endtask

    // FIFO read side and downstream ready, driven on the falling edge.
    always @(negedge clk) begin
        case (rdy_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ($urandom_range(1) == 1);
            default: i_ready = (rdy_pat.size() != 0) ? rdy_pat.pop_front() : 1'b1;
        endcase
        if (fifo.size() == 0 || (gap_en && $urandom_range(3) == 0)) begin
            i_fifo_empty = 1'b1;
            i_fifo_data  = 32'h0BAD_0BAD;
        end else begin
            i_fifo_empty = 1'b0;
            i_fifo_data  = fifo[0];
        end
    end

    // Consume the head word on each edge the DUT pulled it.
    always @(posedge clk) begin
        if (pull_s && fifo.size() != 0) fifo.delete(0);
    end

    // Monitor: samples just before each rising edge.
    always @(negedge clk) begin
        beat_t b;
        stat_t s;
        #4;
        pull_s = o_fifo_pull && !i_fifo_empty;
        if (i_reset) begin
            check("pull_in_reset", o_fifo_pull, 0);
            exp_beats.delete();
            exp_stat.delete();
            seen_seqerr = 0;
            have_prev   = 0;
        end else begin
            check("pull_when_empty", o_fifo_pull && i_fifo_empty, 0);
            if (!i_fifo_empty && (i_ready || !o_valid))
                check("pull_when_free", o_fifo_pull, 1);
            if (o_valid && !i_ready && !o_last && !i_fifo_empty)
                check("pull_while_stalled", o_fifo_pull, 0);
            if (have_prev && prev_valid && !prev_ready)
                check("hold_on_stall", {o_valid, o_first, o_last, o_data}, {1'b1, prev_beat});
            if (o_valid && i_ready) begin
                if (exp_beats.size() == 0) begin
                    check("extra_beat", {o_first, o_last, o_data}, 34'h0);
                    check("extra_beat_valid", o_valid, 0);
                end else begin
                    b = exp_beats.pop_front();
                    check("beat", {o_first, o_last, o_data}, b);
                end
                total_beats++;
            end
            if (o_seq_err) seen_seqerr++;
            if (o_frame_ok || o_crc_err || o_sync_err) begin
                if (exp_stat.size() == 0) begin
                    check("extra_status", {o_frame_ok, o_crc_err, o_sync_err}, 3'b000);
                end else begin
                    s = exp_stat.pop_front();
                    check("status_kind", {o_frame_ok, o_crc_err, o_sync_err},
                          (s.kind == ST_OK) ? 3'b100 : (s.kind == ST_CRC) ? 3'b010 : 3'b001);
                    check("seq_err_count", seen_seqerr, s.seq_err);
                    check("seqnum", o_seqnum, s.seq);
                    check("timestamp", o_timestamp, s.ts);
                    check("cnt_ok", o_cnt_ok, s.cnt_ok);
                    check("cnt_bad", o_cnt_bad, s.cnt_bad);
                end
                seen_seqerr = 0;
            end
            have_prev  = 1;
            prev_valid = o_valid;
            prev_ready = i_ready;
            prev_beat  = {o_first, o_last, o_data};
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        int n;
        logic [14:0] sq;
        i_reset = 1'b1;
        i_ready = 1'b1;
        i_fifo_empty = 1'b1;
        i_fifo_data  = '0;
        m_base = 0; m_prev = '0; m_ok = '0; m_bad = '0;

        // Reset state, with a word waiting in the FIFO that must not be pulled.
        fifo.push_back(32'h1234_5678);
        repeat (3) @(negedge clk);
        #4;
        check("reset_pull", o_fifo_pull, 0);
        check("reset_valid_first_last", {o_valid, o_first, o_last}, 3'b000);
        check("reset_data", o_data, 0);
        check("reset_ts", o_timestamp, 0);
        check("reset_seq", o_seqnum, 0);
        check("reset_pulses", {o_frame_ok, o_crc_err, o_sync_err, o_seq_err}, 4'b0000);
        check("reset_counters", {o_cnt_ok, o_cnt_bad}, 32'h0);
        @(negedge clk);
        i_reset = 1'b0;

        // Counting payload, seq 0, timestamp 0, always ready.
        for (int i = 0; i < NB; i++) pl[i] = i;
        push_frame(15'd0, 64'd0, -1, 0);
        wait_drain(2000);

        // Sequence jump 5 then 7.
        for (int i = 0; i < NB; i++) pl[i] = $urandom;
        push_frame(15'd5, {$urandom, $urandom}, -1, 0);
        for (int i = 0; i < NB; i++) pl[i] = $urandom;
        push_frame(15'd7, {$urandom, $urandom}, -1, 0);
        wait_drain(3000);

        // Bit flip in payload word 17, then a bad trailer tag.
        for (int i = 0; i < NB; i++) pl[i] = $urandom;
        push_frame(15'd8, {$urandom, $urandom}, 17, 0);
        push_frame(15'd9, {$urandom, $urandom}, -1, 1);
        wait_drain(3000);

        // Garbage ahead of a frame, including a header look-alike with bit 15 set.
        fifo.push_back(32'h1234_5678);
        fifo.push_back(32'hCAFE_8000);
        for (int i = 0; i < 5; i++) fifo.push_back($urandom & 32'h7FFF_FFFF);
        for (int i = 0; i < NB; i++) pl[i] = $urandom;
        push_frame(15'd10, {$urandom, $urandom}, -1, 0);
        wait_drain(2000);

        // Downstream ready pattern 1-0-0-1.
        for (int i = 0; i < 300; i++) begin
            rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0);
            rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
        end
        rdy_mode = 2;
        for (int i = 0; i < NB; i++) pl[i] = $urandom;
        push_frame(15'd11, {$urandom, $urandom}, -1, 0);
        wait_drain(3000);
        rdy_pat.delete();
        rdy_mode = 0;

        // Sequence wrap 7FFF -> 0000 is legal.
        for (int i = 0; i < NB; i++) pl[i] = $urandom;
        push_frame(15'h7FFF, {$urandom, $urandom}, -1, 0);
        push_frame(15'h0000, {$urandom, $urandom}, -1, 0);
        wait_drain(3000);

        // Random frames back to back with bubbles, stalls, errors and garbage.
        rdy_mode = 1;
        gap_en   = 1;
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(2) == 0) fifo.push_back($urandom & 32'h7FFF_FFFF);
            for (int i = 0; i < NB; i++) pl[i] = $urandom;
            sq = ($urandom_range(3) == 0) ? 15'($urandom) : 15'(m_prev + 15'd1);
            push_frame(sq, {$urandom, $urandom},
                       ($urandom_range(5) == 0) ? int'($urandom_range(NB - 1)) : -1,
                       $urandom_range(5) == 0);
        end
        wait_drain(20000);
        rdy_mode = 0;
        gap_en   = 0;

        // Reset at payload word 100; leftover words cannot look like a header.
        for (int i = 0; i < NB; i++) pl[i] = $urandom & 32'h7FFF_FFFF;
        b0 = total_beats;
        push_frame(15'd100, {$urandom, $urandom}, -1, 0);
        n = 0;
        while (total_beats < b0 + 100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_word_100", 128'(total_beats >= b0 + 100), 1);
        do_reset(2);
        #4;
        check("valid_after_reset", o_valid, 0);
        check("counters_after_reset", {o_cnt_ok, o_cnt_bad}, 32'h0);
        for (int i = 0; i < NB; i++) pl[i] = $urandom;
        push_frame(15'd200, {$urandom, $urandom}, -1, 0);
        wait_drain(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_frame_checker.md
# rx_frame_checker

Downstream consumer of the RX framer's output FIFO. It pulls 32-bit frame words from the first-word-fall-through read side, locks onto the 0xCAFE header, and latches the sequence number and 64-bit timestamp. It forwards the 256 payload words over a valid/ready stream, recomputes the CRC-16, and checks the 0xC0DE trailer. Per-frame status pulses and saturating counters are exported for the register bank and LEDs.

## Interface
Parameters:
- NB_SAMPLES, 256: payload words per frame, range 1..1023.

Ports:
- i_clk  in  1  single clock for the whole block.
- i_reset  in  1  synchronous, active-high reset.
- i_fifo_empty  in  1  FIFO read side is empty.
- i_fifo_data  in  32  FIFO head word; valid whenever i_fifo_empty=0 (FWFT).
- o_fifo_pull  out  1  combinational; the head word is consumed on the rising edge where this is 1.
- o_valid  out  1  payload word valid.
- o_data  out  32  payload word.
- o_first  out  1  o_data is payload word 0.
- o_last  out  1  o_data is payload word NB_SAMPLES-1.
- i_ready  in  1  downstream accepts o_data when o_valid&i_ready.
- o_timestamp  out  64  timestamp of the current/last frame.
- o_seqnum  out  15  sequence number of the current/last frame.
- o_frame_ok  out  1  1-cycle pulse: trailer and CRC good.
- o_crc_err  out  1  1-cycle pulse: trailer tag good, CRC mismatch.
- o_sync_err  out  1  1-cycle pulse: trailer tag is not 0xC0DE.
- o_seq_err  out  1  1-cycle pulse: header seqnum is not previous+1.
- o_cnt_ok  out  16  frames good, saturating.
- o_cnt_bad  out  16  crc+sync errors, saturating.

## Operation
- Frame format: H = {16'hCAFE, 1'b0, seq[14:0]}, then TS[63:32], TS[31:0], then NB_SAMPLES payload words, then F = {16'hC0DE, crc[15:0]}.
- CRC: poly 0x1021, init 0xFFFF at header accept, no reflection, no final XOR, computed over payload words only. Per word, 32 left-shift steps taking data bit 31 first: c = {c[14:0],1'b0} ^ ((c[15]^d) ? 16'h1021 : 0).
- FSM states: HUNT, TS_MSB, TS_LSB, PAYLOAD, FCS. Reset state is HUNT.
  - HUNT: discard words until i_fifo_data[31:15] == {16'hCAFE,1'b0}. On match, latch seq, crc<=FFFF, go to TS_MSB.
  - TS_MSB: latch o_timestamp[63:32] (word accepted unchecked), go to TS_LSB.
  - TS_LSB: latch [31:0], count<=NB_SAMPLES-1, go to PAYLOAD.
  - PAYLOAD: forward each word and update the CRC. Count decrements; after the word taken at count==0, go to FCS.
  - FCS: consume one word, always return to HUNT.
    - [31:16]!=C0DE: o_sync_err, cnt_bad++.
    - Otherwise [15:0]==crc: o_frame_ok, cnt_ok++.
    - Otherwise: o_crc_err, cnt_bad++.
- Seq check at header accept: the first header after reset only sets the baseline. After that, seq != (prev+1) mod 2^15 pulses o_seq_err; the frame is still processed. 7FFF -> 0000 is legal.
- Pull rule: o_fifo_pull = !i_fifo_empty && !i_reset && (state!=PAYLOAD || !o_valid || i_ready). Non-payload words never stall.
- Counters hold at FFFF.

## Timing
- Reset values: o_valid, o_first, o_last and all pulses 0. o_data, o_timestamp, o_seqnum, counters 0. CRC FFFF. Baseline cleared.
- Reset mid-frame discards the partial frame. Words already in the FIFO are re-hunted from HUNT.
- Payload latency: 1 cycle. A word pulled at edge k appears on o_data/o_valid right after edge k.
- o_data, o_first and o_last hold while o_valid&!i_ready.
- o_valid drops after an accept edge with no new pull.
- Status pulses assert for the cycle after the FCS pull edge. o_seq_err asserts for the cycle after the header pull edge.
- The FCS word may be pulled on the same edge the last payload word is accepted downstream.
- Throughput: 1 word/cycle with i_ready=1 and the FIFO non-empty. A frame takes NB_SAMPLES+4 pull cycles.

## Test plan
- Frame seq 0, TS 0, payload 0..255, correct CRC, i_ready=1 -> 256 beats with o_first on word 0 and o_last on word 255; o_frame_ok pulse; o_cnt_ok=1; o_timestamp=0.
- Two frames, seq 5 then 7 -> o_seq_err one cycle after the second header; both frames o_frame_ok.
- Payload word 17 bit-flipped -> o_crc_err; o_cnt_bad=1; all 256 words still forwarded.
- Garbage words 0x12345678, 0xCAFE8000 (bit15 set), then a valid frame -> garbage discarded with no o_valid; frame received OK.
- i_ready toggling 1-0-0-1 -> no word lost or duplicated; o_fifo_pull=0 while stalled with o_valid=1.
- i_reset at payload word 100, then a full frame -> o_valid=0 after reset; next frame OK; no o_seq_err; counters restart from 0.
